// File: rtl/uart_rx_core_pkg.sv
// Shared UART types and constants.
// Used by the receive engine and its sibling blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int UART_CLKS_PER_BIT_9600 = 10416;
  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_core_if.sv
// Byte handshake and status bundle between the
// receive engine and the register block.
interface uart_rx_core_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic frame_err;
  logic overrun_err;
  logic rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun_err,
    output rx_busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun_err,
    input  rx_busy,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_core_sync2.sv
// Two-flop synchronizer for asynchronous pins,
// with a selectable reset level.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 receive engine: mid-bit sampling of the
// synchronized pin, byte handoff over valid/ready.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_9600
) (
  input  logic pClk,
  input  logic pReset,
  input  logic RxD,
  uart_rx_core_if.master rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int DW = UART_DATA_BITS;
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_IDX = 3'(DW - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 4");
  end

  logic rxd_s;

  uart_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_i(pClk),
    .rst_i(pReset),
    .d_i  (RxD),
    .q_o  (rxd_s)
  );

  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic ferr_q, ferr_d;
  logic ovr_q, ovr_d;
  logic deliver;
  logic tick_half;
  logic tick_full;

  assign tick_half = (cnt_q == HALF_M1);
  assign tick_full = (cnt_q == FULL_M1);

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxd_s) state_d = START;
      end
      START: begin
        if (tick_half) begin
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (tick_full) begin
          shift_d[idx_q] = rxd_s;
          // each sample restarts the bit period
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick_full) begin
          if (rxd_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxd_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    // a same-cycle accept frees the slot
    if (deliver) begin
      if (!valid_q || rx.rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  assign rx.rx_data     = data_q;
  assign rx.rx_valid    = valid_q;
  assign rx.frame_err   = ferr_q;
  assign rx.overrun_err = ovr_q;
  assign rx.rx_busy     = (state_q != IDLE);

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive engine for the UART: it recovers 8N1 frames from the asynchronous `RxD` pin and hands complete bytes to the register block's Rx data register (address 1) over a valid/ready handshake. It sits between the pad and the register block. It also reports framing and overrun errors so the register block can raise status bits and IRQs. At the default setting it runs at 9600 baud from the 100 MHz `pClk`, which gives 10416 clocks per bit.

## Interface
- `CLKS_PER_BIT`, 10416 — `pClk` cycles per bit period. Legal values are ≥ 4, checked at elaboration.
- `pClk` in 1 — system clock; everything is on its rising edge.
- `pReset` in 1 — asynchronous, active-high reset.
- `RxD` in 1 — serial input, asynchronous, idle high.
- `rx_data` out 8 — received byte, valid while `rx_valid`=1.
- `rx_valid` out 1 — byte available; held until accepted.
- `rx_ready` in 1 — consumer accepts the byte on any cycle where `rx_valid` & `rx_ready` are both 1.
- `frame_err` out 1 — one-cycle pulse when the stop bit is sampled low.
- `overrun_err` out 1 — one-cycle pulse when a good byte is dropped because `rx_valid` is still 1.
- `rx_busy` out 1 — high in every state except IDLE.

## Operation
- `RxD` passes through a 2-flop synchronizer, giving `rxd_s`. Sampling uses `rxd_s` only.
- Counters:
  - `baud_cnt` is `$clog2(CLKS_PER_BIT)` bits wide. It clears on every state entry and increments otherwise.
  - `HALF` = `CLKS_PER_BIT/2`, using integer division.
  - `bit_idx` is 3 bits.
- FSM states are IDLE, START, DATA, STOP and WAIT_IDLE.
  - **IDLE:** when `rxd_s`=0, go to START.
  - **START:** at `baud_cnt`=`HALF`-1, sample `rxd_s`.
    - If 0, go to DATA with `bit_idx`=0.
    - If 1 (glitch or false start), go to IDLE. No flag is raised.
  - **DATA:** at `baud_cnt`=`CLKS_PER_BIT`-1, write `shift[bit_idx]` ← `rxd_s`. Bits arrive LSB first.
    - If `bit_idx`=7, go to STOP.
    - Otherwise increment `bit_idx`.
  - **STOP:** at `baud_cnt`=`CLKS_PER_BIT`-1, sample `rxd_s`.
    - If 1, deliver the byte and go to IDLE.
    - If 0, pulse `frame_err`, discard the byte and go to WAIT_IDLE.
  - **WAIT_IDLE:** stay here, absorbing a break or stuck-low line, until `rxd_s`=1. Then go to IDLE.
- Delivery:
  - If `rx_valid`=0, or `rx_ready`=1 in the same cycle, load `rx_data` ← `shift` and set `rx_valid`=1.
  - Otherwise keep the old `rx_data`, drop the new byte and pulse `overrun_err`.
- Handshake:
  - `rx_valid` clears on the cycle after `rx_valid`&`rx_ready`, unless a delivery happens in that same cycle.
  - `rx_data` is stable while `rx_valid`=1.
- Reception continues while a byte is pending; the FSM never stalls on `rx_ready`.

## Timing
- Reset values:
  - `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `overrun_err`=0, `rx_busy`=0.
  - FSM in IDLE, counters at 0.
  - Both synchronizer flops are set to 1, so no false start comes out of reset.
- Reset may assert mid-frame. All state clears immediately (asynchronous) and the partial byte is lost.
- Sample points, with E = the edge where `rxd_s` first goes low:
  - Start bit is confirmed at E+`HALF`.
  - Data bit k is sampled at E+`HALF`+(k+1)·`CLKS_PER_BIT`.
  - Stop bit is sampled at E+`HALF`+9·`CLKS_PER_BIT`.
- `rx_valid`, `frame_err` and `overrun_err` assert on the clock edge after the stop-bit sample.
- Pin-to-`rxd_s` latency is 2 cycles.
- A new start bit is accepted from the first IDLE cycle. Back-to-back frames, with the next start bit immediately after the stop bit, must be received without loss.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum `rx_state_t` (IDLE, START, DATA, STOP, WAIT_IDLE);
  - the constant `UART_CLKS_PER_BIT_9600` = 10416;
  - the constant `UART_DATA_BITS` = 8.
- One sub-module, `uart_sync2`: a 2-flop synchronizer with a reset value parameter (1 here). The Tx/button paths reuse it.

## Test plan
- **Byte at full rate:** `CLKS_PER_BIT`=10416, drive 8'd20 with a 104160 ns bit time, `rx_ready`=1 → one `rx_valid` pulse with `rx_data`=8'h14, no errors.
- **Back-to-back frames:** `CLKS_PER_BIT`=16, send 8'h55 then 8'hAA with no idle gap, `rx_ready`=1 → two deliveries in order: 8'h55, then 8'hAA.
- **Glitch rejection:** `RxD` low for 5 cycles (< `HALF`=8) → returns to IDLE, no `rx_valid`, no `frame_err`.
- **Framing error:** send 8'hF0 with the stop bit held low for 40 cycles → `frame_err` pulses once, no `rx_valid`. `rx_busy` stays 1 until the line goes high, then the next frame 8'h3C is received correctly.
- **Overrun:** `rx_ready`=0, send 8'h11 then 8'h22 → `rx_data` stays 8'h11 and `overrun_err` pulses at the end of frame 2. Raising `rx_ready` clears `rx_valid` one cycle later.
- **Reset mid-frame:** assert `pReset` during DATA bit 3 of 8'hC3 → all outputs return to reset values immediately. After release, a fresh 8'h5A is received correctly.
